ysyx_25030081_idu: RTL and testbench

YSYX_25030081_IDU -- requirements
Module: ysyx_25030081_idu

---
 rtl/ysyx_25030081_pkg.sv | 93 +++++++++
 rtl/ysyx_25030081_immgen.sv | 25 ++
 rtl/ysyx_25030081_idu.sv | 220 ++++++++++++++++++++++
 tb/tb_ysyx_25030081_idu.sv | 232 +++++++++++++++++++++++
 4 files changed

// File: rtl/ysyx_25030081_pkg.sv
// Shared decode constants: ALU op codes, opcodes, instruction classes, IDU bundle.
package ysyx_25030081_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned REG_AW   = 5;
  localparam int unsigned ALU_OP_W = 4;
  localparam int unsigned CLS_W    = 3;

  typedef enum logic [ALU_OP_W-1:0] {
    ALU_ADD      = 4'b0000,
    ALU_SUB      = 4'b1000,
    ALU_SLL      = 4'b0001,
    ALU_SLT      = 4'b0010,
    ALU_SLTU     = 4'b1010,
    ALU_PASS_OP2 = 4'b0011,
    ALU_XOR      = 4'b0100,
    ALU_SRL      = 4'b0101,
    ALU_SRA      = 4'b1101,
    ALU_OR       = 4'b0110,
    ALU_AND      = 4'b0111
  } alu_op_e;

  typedef enum logic [CLS_W-1:0] {
    CLS_ALU    = 3'd0,
    CLS_LOAD   = 3'd1,
    CLS_STORE  = 3'd2,
    CLS_BRANCH = 3'd3,
    CLS_JUMP   = 3'd4,
    CLS_SYSTEM = 3'd5
  } cls_e;

  typedef enum logic [2:0] {
    IMM_NONE = 3'd0,
    IMM_I    = 3'd1,
    IMM_S    = 3'd2,
    IMM_B    = 3'd3,
    IMM_U    = 3'd4,
    IMM_J    = 3'd5
  } imm_type_e;

  typedef enum logic {
    ST_EMPTY = 1'b0,
    ST_FULL  = 1'b1
  } idu_state_e;

  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [XLEN-1:0] INST_ECALL  = 32'h0000_0073;
  localparam logic [XLEN-1:0] INST_EBREAK = 32'h0010_0073;

  localparam logic [6:0] F7_BASE = 7'b0000000;
  localparam logic [6:0] F7_ALT  = 7'b0100000;

  typedef struct packed {
    alu_op_e           alu_op;
    logic [XLEN-1:0]   op1;
    logic [XLEN-1:0]   op2;
    logic [XLEN-1:0]   rs2_val;
    logic [XLEN-1:0]   pc;
    logic [XLEN-1:0]   target;
    logic [REG_AW-1:0] rd;
    logic              rd_wen;
    cls_e              cls;
    logic [2:0]        funct3;
    logic              illegal;
  } idu_bundle_t;

  // Map funct3 (plus the SUB/SRA alternate bit) onto the ALU encoding.
  function automatic alu_op_e alu_op_from_f3(input logic [2:0] f3, input logic alt);
    alu_op_e op;
    case (f3)
      3'b000:  op = alt ? ALU_SUB : ALU_ADD;
      3'b001:  op = ALU_SLL;
      3'b010:  op = ALU_SLT;
      3'b011:  op = ALU_SLTU;
      3'b100:  op = ALU_XOR;
      3'b101:  op = alt ? ALU_SRA : ALU_SRL;
      3'b110:  op = ALU_OR;
      default: op = ALU_AND;
    endcase
    return op;
  endfunction

endpackage

// File: rtl/ysyx_25030081_immgen.sv
// Sign-extended immediate extraction for the I/S/B/U/J formats.
module ysyx_25030081_immgen
  import ysyx_25030081_pkg::*;
(
  input  logic [XLEN-1:0] i_inst,
  input  imm_type_e       i_imm_type,
  output logic [XLEN-1:0] o_imm32_c
);

  // Select the immediate layout for the requested format.
  always_comb begin
    o_imm32_c = '0;
    case (i_imm_type)
      IMM_I:   o_imm32_c = {{20{i_inst[31]}}, i_inst[31:20]};
      IMM_S:   o_imm32_c = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
      IMM_B:   o_imm32_c = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25],
                            i_inst[11:8], 1'b0};
      IMM_U:   o_imm32_c = {i_inst[31:12], 12'd0};
      IMM_J:   o_imm32_c = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20],
                            i_inst[30:21], 1'b0};
      default: o_imm32_c = '0;
    endcase
  end

endmodule

// File: rtl/ysyx_25030081_idu.sv
// RV32I decode stage: single-entry skid-free output register with valid/ready handshake.
module ysyx_25030081_idu
  import ysyx_25030081_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [DATA_WIDTH-1:0] in_inst,
  input  logic [DATA_WIDTH-1:0] in_pc,
  output logic [4:0]            rs1_addr,
  output logic [4:0]            rs2_addr,
  input  logic [DATA_WIDTH-1:0] rs1_data,
  input  logic [DATA_WIDTH-1:0] rs2_data,
  input  logic                  flush,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [3:0]            alu_op,
  output logic [DATA_WIDTH-1:0] op1,
  output logic [DATA_WIDTH-1:0] op2,
  output logic [DATA_WIDTH-1:0] rs2_val,
  output logic [DATA_WIDTH-1:0] pc,
  output logic [DATA_WIDTH-1:0] target,
  output logic [4:0]            rd,
  output logic                  rd_wen,
  output logic [2:0]            cls,
  output logic [2:0]            funct3,
  output logic                  illegal
);

  idu_state_e        r_state;
  idu_state_e        w_state_nxt;
  idu_bundle_t       r_bundle;
  idu_bundle_t       w_bundle;
  logic              w_load;
  imm_type_e         w_imm_type;
  logic [XLEN-1:0]   w_imm;
  logic [XLEN-1:0]   w_jalr_sum;
  logic              w_illegal;
  logic              w_wb;

  logic [6:0]        w_opcode;
  logic [2:0]        w_f3;
  logic [6:0]        w_f7;
  logic [REG_AW-1:0] w_rd;

  assign w_opcode = in_inst[6:0];
  assign w_f3     = in_inst[14:12];
  assign w_f7     = in_inst[31:25];
  assign w_rd     = in_inst[11:7];
  assign rs1_addr = in_inst[19:15];
  assign rs2_addr = in_inst[24:20];

  // Immediate format follows the opcode.
  always_comb begin
    w_imm_type = IMM_NONE;
    case (w_opcode)
      OPC_OP_IMM, OPC_JALR, OPC_LOAD: w_imm_type = IMM_I;
      OPC_STORE:                      w_imm_type = IMM_S;
      OPC_BRANCH:                     w_imm_type = IMM_B;
      OPC_LUI, OPC_AUIPC:             w_imm_type = IMM_U;
      OPC_JAL:                        w_imm_type = IMM_J;
      default:                        w_imm_type = IMM_NONE;
    endcase
  end

  ysyx_25030081_immgen u_immgen (
    .i_inst     (in_inst),
    .i_imm_type (w_imm_type),
    .o_imm32_c  (w_imm)
  );

  assign w_jalr_sum = rs1_data + w_imm;

  // Decode the offered instruction into the next bundle.
  always_comb begin
    w_bundle         = '0;
    w_bundle.alu_op  = ALU_ADD;
    w_bundle.cls     = CLS_ALU;
    w_bundle.pc      = in_pc;
    w_bundle.rs2_val = rs2_data;
    w_bundle.rd      = w_rd;
    w_bundle.funct3  = w_f3;
    w_illegal        = 1'b0;
    w_wb             = 1'b0;
    case (w_opcode)
      OPC_OP: begin
        w_bundle.op1 = rs1_data;
        w_bundle.op2 = rs2_data;
        w_wb         = 1'b1;
        if (w_f7 == F7_BASE || (w_f7 == F7_ALT && (w_f3 == 3'b000 || w_f3 == 3'b101)))
          w_bundle.alu_op = alu_op_from_f3(w_f3, w_f7[5]);
        else
          w_illegal = 1'b1;
      end
      OPC_OP_IMM: begin
        w_bundle.op1 = rs1_data;
        w_wb         = 1'b1;
        if (w_f3 == 3'b001) begin
          w_bundle.op2    = {27'd0, w_imm[4:0]};
          w_bundle.alu_op = ALU_SLL;
          w_illegal       = (w_f7 != F7_BASE);
        end else if (w_f3 == 3'b101) begin
          w_bundle.op2    = {27'd0, w_imm[4:0]};
          w_bundle.alu_op = w_imm[10] ? ALU_SRA : ALU_SRL;
          w_illegal       = (w_f7 != F7_BASE) && (w_f7 != F7_ALT);
        end else begin
          w_bundle.op2    = w_imm;
          w_bundle.alu_op = alu_op_from_f3(w_f3, 1'b0);
        end
      end
      OPC_LUI: begin
        w_bundle.op2    = w_imm;
        w_bundle.alu_op = ALU_PASS_OP2;
        w_wb            = 1'b1;
      end
      OPC_AUIPC: begin
        w_bundle.op1 = in_pc;
        w_bundle.op2 = w_imm;
        w_wb         = 1'b1;
      end
      OPC_JAL: begin
        w_bundle.op1    = in_pc;
        w_bundle.op2    = XLEN'(4);
        w_bundle.target = in_pc + w_imm;
        w_bundle.cls    = CLS_JUMP;
        w_wb            = 1'b1;
      end
      OPC_JALR: begin
        w_bundle.op1    = in_pc;
        w_bundle.op2    = XLEN'(4);
        w_bundle.target = {w_jalr_sum[XLEN-1:1], 1'b0};
        w_bundle.cls    = CLS_JUMP;
        w_wb            = 1'b1;
      end
      OPC_LOAD: begin
        w_bundle.op1 = rs1_data;
        w_bundle.op2 = w_imm;
        w_bundle.cls = CLS_LOAD;
        w_wb         = 1'b1;
        w_illegal    = (w_f3 == 3'b011) || (w_f3 == 3'b110) || (w_f3 == 3'b111);
      end
      OPC_STORE: begin
        w_bundle.op1 = rs1_data;
        w_bundle.op2 = w_imm;
        w_bundle.cls = CLS_STORE;
        w_illegal    = (w_f3 > 3'b010);
      end
      OPC_BRANCH: begin
        w_bundle.op1    = rs1_data;
        w_bundle.op2    = rs2_data;
        w_bundle.target = in_pc + w_imm;
        w_bundle.cls    = CLS_BRANCH;
        case (w_f3[2:1])
          2'b00:   w_bundle.alu_op = ALU_SUB;
          2'b10:   w_bundle.alu_op = ALU_SLT;
          2'b11:   w_bundle.alu_op = ALU_SLTU;
          default: w_illegal       = 1'b1;
        endcase
      end
      OPC_SYSTEM: begin
        w_bundle.cls = CLS_SYSTEM;
        w_illegal    = (in_inst != INST_ECALL) && (in_inst != INST_EBREAK);
      end
      default: w_illegal = 1'b1;
    endcase
    if (w_illegal) begin
      w_bundle.cls    = CLS_SYSTEM;
      w_bundle.target = '0;
    end
    w_bundle.illegal = w_illegal;
    w_bundle.rd_wen  = w_wb && !w_illegal && (w_rd != '0);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) r_state <= ST_EMPTY;
    else        r_state <= w_state_nxt;
  end

  // Handshake and next-state; flush wins over both consume and transfer.
  always_comb begin
    w_state_nxt = r_state;
    in_ready    = 1'b0;
    w_load      = 1'b0;
    in_ready    = ((r_state == ST_EMPTY) || out_ready) && !flush;
    w_load      = in_valid && in_ready;
    if (flush) begin
      w_state_nxt = ST_EMPTY;
    end else begin
      case (r_state)
        ST_EMPTY: if (w_load) w_state_nxt = ST_FULL;
        ST_FULL:  if (out_ready && !w_load) w_state_nxt = ST_EMPTY;
        default:  w_state_nxt = ST_EMPTY;
      endcase
    end
  end

  // Payload register captures the decoded bundle on transfer.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)      r_bundle <= '0;
    else if (w_load) r_bundle <= w_bundle;
  end

  assign out_valid = (r_state == ST_FULL);
  assign alu_op    = r_bundle.alu_op;
  assign op1       = r_bundle.op1;
  assign op2       = r_bundle.op2;
  assign rs2_val   = r_bundle.rs2_val;
  assign pc        = r_bundle.pc;
  assign target    = r_bundle.target;
  assign rd        = r_bundle.rd;
  assign rd_wen    = r_bundle.rd_wen;
  assign cls       = r_bundle.cls;
  assign funct3    = r_bundle.funct3;
  assign illegal   = r_bundle.illegal;

endmodule

// File: tb/tb_ysyx_25030081_idu.sv
// Directed bench for the decode stage: decode fields, handshake, flush and reset.
module tb_ysyx_25030081_idu;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_inst;
  logic [31:0] in_pc;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  alu_op;
  logic [31:0] op1;
  logic [31:0] op2;
  logic [31:0] rs2_val;
  logic [31:0] pc;
  logic [31:0] target;
  logic [4:0]  rd;
  logic        rd_wen;
  logic [2:0]  cls;
  logic [2:0]  funct3;
  logic        illegal;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  ysyx_25030081_idu #(.DATA_WIDTH(32)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_inst   (in_inst),
    .in_pc     (in_pc),
    .rs1_addr  (rs1_addr),
    .rs2_addr  (rs2_addr),
    .rs1_data  (rs1_data),
    .rs2_data  (rs2_data),
    .flush     (flush),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .alu_op    (alu_op),
    .op1       (op1),
    .op2       (op2),
    .rs2_val   (rs2_val),
    .pc        (pc),
    .target    (target),
    .rd        (rd),
    .rd_wen    (rd_wen),
    .cls       (cls),
    .funct3    (funct3),
    .illegal   (illegal)
  );

  // Advance to just after the next rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; in_valid = 1'b0; in_inst = 32'h0; in_pc = 32'h0;
    rs1_data = 32'h0; rs2_data = 32'h0; flush = 1'b0; out_ready = 1'b1;
    tick(); tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_out_valid got %h exp 0", out_valid); end
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL reset_in_ready got %h exp 1", in_ready); end
    checks++; if ({alu_op, op1, op2, target, rd, rd_wen, cls, illegal} !== '0) begin
      errors++; $display("FAIL reset_payload got alu %h op1 %h op2 %h tgt %h exp all 0", alu_op, op1, op2, target);
    end
    rst_n = 1'b1;
    tick();
  endtask

  task automatic test_sub();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'h4020_8133; in_pc = 32'h0000_1000;
    rs1_data = 32'd5; rs2_data = 32'd3;
    #1;
    checks++; if (rs1_addr !== 5'd1 || rs2_addr !== 5'd2) begin errors++; $display("FAIL sub_rs_addr got %0d/%0d exp 1/2", rs1_addr, rs2_addr); end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_pre_valid got %h exp 0", out_valid); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL sub_valid got %h exp 1", out_valid); end
    checks++; if (alu_op !== 4'b1000) begin errors++; $display("FAIL sub_alu_op got %b exp 1000", alu_op); end
    checks++; if (op1 !== 32'd5 || op2 !== 32'd3) begin errors++; $display("FAIL sub_ops got %h/%h exp 5/3", op1, op2); end
    checks++; if (rd !== 5'd2 || rd_wen !== 1'b1 || cls !== 3'd0 || illegal !== 1'b0) begin
      errors++; $display("FAIL sub_rd got rd %0d wen %h cls %0d ill %h exp 2 1 0 0", rd, rd_wen, cls, illegal);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL sub_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_srai();
    in_valid = 1'b1; in_inst = 32'h4020_D093; rs1_data = 32'h8000_0000; rs2_data = 32'h0;
    tick(); in_valid = 1'b0;
    checks++; if (alu_op !== 4'b1101 || op2 !== 32'd2 || op1 !== 32'h8000_0000) begin
      errors++; $display("FAIL srai got alu %b op1 %h op2 %h exp 1101 80000000 2", alu_op, op1, op2);
    end
    checks++; if (rd !== 5'd1 || rd_wen !== 1'b1 || illegal !== 1'b0) begin
      errors++; $display("FAIL srai_rd got rd %0d wen %h ill %h exp 1 1 0", rd, rd_wen, illegal);
    end
    tick();
  endtask

  task automatic test_lui();
    in_valid = 1'b1; in_inst = 32'h1234_50B7;
    tick(); in_valid = 1'b0;
    checks++; if (alu_op !== 4'b0011 || op2 !== 32'h1234_5000 || op1 !== 32'h0) begin
      errors++; $display("FAIL lui got alu %b op1 %h op2 %h exp 0011 0 12345000", alu_op, op1, op2);
    end
    tick();
  endtask

  task automatic test_jal();
    in_valid = 1'b1; in_inst = 32'h0100_00EF; in_pc = 32'h0000_0100;
    tick(); in_valid = 1'b0;
    checks++; if (alu_op !== 4'b0000 || op1 !== 32'h100 || op2 !== 32'd4) begin
      errors++; $display("FAIL jal_ops got alu %b op1 %h op2 %h exp 0000 100 4", alu_op, op1, op2);
    end
    checks++; if (target !== 32'h110 || rd_wen !== 1'b1 || cls !== 3'd4) begin
      errors++; $display("FAIL jal_tgt got tgt %h wen %h cls %0d exp 110 1 4", target, rd_wen, cls);
    end
    tick();
  endtask

  task automatic test_branch();
    // bltu x3, x4, -8 with rd field = 25
    in_valid = 1'b1; in_inst = 32'hFE41_ECE3; in_pc = 32'h8000_0000;
    rs1_data = 32'h0000_0011; rs2_data = 32'h0000_0022;
    #1;
    checks++; if (rs1_addr !== 5'd3 || rs2_addr !== 5'd4) begin errors++; $display("FAIL br_rs_addr got %0d/%0d exp 3/4", rs1_addr, rs2_addr); end
    tick(); in_valid = 1'b0;
    checks++; if (alu_op !== 4'b1010 || target !== 32'h7FFF_FFF8) begin
      errors++; $display("FAIL br_alu_tgt got alu %b tgt %h exp 1010 7ffffff8", alu_op, target);
    end
    checks++; if (rd_wen !== 1'b0 || cls !== 3'd3 || funct3 !== 3'd6) begin
      errors++; $display("FAIL br_ctl got wen %h cls %0d f3 %0d exp 0 3 6", rd_wen, cls, funct3);
    end
    checks++; if (op1 !== 32'h11 || op2 !== 32'h22 || rs2_val !== 32'h22 || pc !== 32'h8000_0000) begin
      errors++; $display("FAIL br_data got op1 %h op2 %h rs2v %h pc %h exp 11 22 22 80000000", op1, op2, rs2_val, pc);
    end
    tick();
  endtask

  task automatic test_back_to_back();
    rs1_data = 32'h0; rs2_data = 32'h0; in_pc = 32'h200;
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0070_0293;   // addi x5, x0, 7
    tick();
    in_inst = 32'h0090_0313;                                     // addi x6, x0, 9
    for (int i = 0; i < 3; i++) begin
      checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin
        errors++; $display("FAIL bp_hold%0d got valid %h ready %h exp 1 0", i, out_valid, in_ready);
      end
      checks++; if (rd !== 5'd5 || op2 !== 32'd7 || alu_op !== 4'b0000 || pc !== 32'h200) begin
        errors++; $display("FAIL bp_stable%0d got rd %0d op2 %h alu %b pc %h exp 5 7 0000 200", i, rd, op2, alu_op, pc);
      end
      tick();
    end
    out_ready = 1'b1;
    #1;
    checks++; if (in_ready !== 1'b1) begin errors++; $display("FAIL bp_release_ready got %h exp 1", in_ready); end
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || rd !== 5'd6 || op2 !== 32'd9) begin
      errors++; $display("FAIL b2b got valid %h rd %0d op2 %h exp 1 6 9", out_valid, rd, op2);
    end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL b2b_drain got %h exp 0", out_valid); end
  endtask

  task automatic test_flush();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0070_0293;
    tick();
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL flush_fill got %h exp 1", out_valid); end
    out_ready = 1'b1; flush = 1'b1; in_inst = 32'h0090_0313;
    #1;
    checks++; if (in_ready !== 1'b0) begin errors++; $display("FAIL flush_ready got %h exp 0", in_ready); end
    tick(); flush = 1'b0; in_valid = 1'b0;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_drop got %h exp 0", out_valid); end
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL flush_noaccept got %h exp 0", out_valid); end
  endtask

  task automatic test_illegal();
    out_ready = 1'b1; in_valid = 1'b1; in_inst = 32'hFFFF_FFFF;
    tick(); in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || illegal !== 1'b1 || rd_wen !== 1'b0 || cls !== 3'd5) begin
      errors++; $display("FAIL illegal got valid %h ill %h wen %h cls %0d exp 1 1 0 5", out_valid, illegal, rd_wen, cls);
    end
    tick();
    // OP with bad funct7 (0x0220_8133: funct7 = 0000001)
    in_valid = 1'b1; in_inst = 32'h0220_8133;
    tick(); in_valid = 1'b0;
    checks++; if (illegal !== 1'b1 || rd_wen !== 1'b0) begin
      errors++; $display("FAIL op_bad_f7 got ill %h wen %h exp 1 0", illegal, rd_wen);
    end
    tick();
  endtask

  task automatic test_reset_mid();
    out_ready = 1'b0; in_valid = 1'b1; in_inst = 32'h0070_0293;
    tick(); in_valid = 1'b0;
    rst_n = 1'b0;
    #1;
    checks++; if (out_valid !== 1'b0 || op2 !== 32'h0 || rd !== 5'd0) begin
      errors++; $display("FAIL reset_mid got valid %h op2 %h rd %0d exp 0 0 0", out_valid, op2, rd);
    end
    tick();
    rst_n = 1'b1; out_ready = 1'b1;
    tick();
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_mid_after got %h exp 0", out_valid); end
  endtask

  initial begin
    test_reset();
    test_sub();
    test_srai();
    test_lui();
    test_jal();
    test_branch();
    test_back_to_back();
    test_flush();
    test_illegal();
    test_reset_mid();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
